// File: rtl/cordic_sincos_if.sv
// cordic_sincos_if -- request/result bundle for the CORDIC sine/cosine engine.
//
// Handshake: the controller raises start with a valid angle. The engine only
// looks at start while it is idle and captures angle on that same edge.
// done is a one-cycle pulse. out_x and out_y are valid from that pulse until
// the next pulse. There is no back-pressure: a result is never stalled.
//
// Signals:
//   start  controller -> engine  request a computation
//   angle  controller -> engine  32-bit first-quadrant angle, 2^32 = pi/2
//   done   engine -> controller  one-cycle result strobe
//   out_x  engine -> controller  cos(angle), unsigned Q1.31
//   out_y  engine -> controller  sin(angle), unsigned Q1.31
interface cordic_sincos_if;
  logic        start;
  logic [31:0] angle;
  logic        done;
  logic [31:0] out_x;
  logic [31:0] out_y;

  modport master (output start, angle, input done, out_x, out_y);
  modport slave  (input start, angle, output done, out_x, out_y);
endinterface

// File: rtl/cordic_sincos.sv
// cordic_sincos -- iterative CORDIC rotation engine that computes cos/sin of a
// first-quadrant angle. It performs one micro-rotation per clock. A result
// arrives 33 cycles after start is accepted.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset; takes priority over start
//   bus        cordic_sincos_if.slave (start, angle, done, out_x, out_y)
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Build option:
//   CORDIC_SATURATE_EN  when defined, the rounded results are clamped to
//                       [0, 0x8000_0000]. When undefined, the low 32 bits
//                       are output as-is, so a small negative residue wraps.
module cordic_sincos (
  input  logic              clk,
  input  logic              reset,
  cordic_sincos_if.slave    bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // round(K * 2^33), where K is the CORDIC gain for 32 iterations. Loading
  // this as x cancels the gain, so |(x, y)| ends at 1.0.
  localparam logic signed [35:0] X_INIT = 36'sd5216262993;

  // round(atan(2^-i) / (pi/2) * 2^32), in angle units.
  localparam logic [31:0] ATAN_LUT [32] = '{
    32'd2147483648, 32'd1267733622, 32'd669835629,  32'd340019024,
    32'd170669324,  32'd85417861,   32'd42719353,   32'd21360980,
    32'd10680653,   32'd5340347,    32'd2670176,    32'd1335088,
    32'd667544,     32'd333772,     32'd166886,     32'd83443,
    32'd41722,      32'd20861,      32'd10430,      32'd5215,
    32'd2608,       32'd1304,       32'd652,        32'd326,
    32'd163,        32'd81,         32'd41,         32'd20,
    32'd10,         32'd5,          32'd3,          32'd1
  };

  state_t             state_q, state_d;
  logic signed [35:0] x_q, y_q;
  logic signed [33:0] z_q;
  logic [4:0]         i_q;
  logic               done_q;
  logic [31:0]        out_x_q, out_y_q;

  logic signed [35:0] x_sh, y_sh, x_nx, y_nx;
  logic signed [33:0] a_ext, z_nx;
  logic signed [35:0] x_sum, y_sum;
  logic [31:0]        x_res, y_res;
  logic               unused_ok;

  assign bus.done  = done_q;
  assign bus.out_x = out_x_q;
  assign bus.out_y = out_y_q;
  assign dbg_state = state_q;

  // One micro-rotation. The sign of the residual angle picks the direction.
  always_comb begin
    x_sh  = x_q >>> i_q;
    y_sh  = y_q >>> i_q;
    a_ext = $signed({2'b00, ATAN_LUT[i_q]});
    if (!z_q[33]) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - a_ext;
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + a_ext;
    end
  end

  // Round value*2^33 to Q1.31: (v + 2) >>> 2, keeping bits [33:2] of the sum.
  assign x_sum = x_q + 36'sd2;
  assign y_sum = y_q + 36'sd2;

  always_comb begin
    x_res = x_sum[33:2];
    y_res = y_sum[33:2];
`ifdef CORDIC_SATURATE_EN
    if (x_sum[35])                          x_res = '0;
    else if (x_sum[34:2] > 33'h0_8000_0000) x_res = 32'h8000_0000;
    if (y_sum[35])                          y_res = '0;
    else if (y_sum[34:2] > 33'h0_8000_0000) y_res = 32'h8000_0000;
`endif
  end

  // These sum bits only matter when clamping is built in.
  assign unused_ok = ^{x_sum[35:34], x_sum[1:0], y_sum[35:34], y_sum[1:0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (i_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q <= X_INIT;
            y_q <= '0;
            z_q <= {2'b00, bus.angle};
            i_q <= '0;
          end
        end
        S_RUN: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          i_q <= i_q + 5'd1;
        end
        S_DONE: begin
          out_x_q <= x_res;
          out_y_q <= y_res;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// tb_cordic_sincos -- directed bench for cordic_sincos. It uses hand-computed
// cos/sin vectors, the start-to-done latency, the throughput with start held
// high, start and angle changes during RUN, and reset during RUN.
module tb_cordic_sincos;

  localparam int TOL     = 64;
  localparam int MAX_WAIT = 100;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  cordic_sincos_if bus ();

  cordic_sincos dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp, input int tol);
    logic signed [31:0] d;
    int ad;
    d  = got - exp;
    ad = (d < 0) ? -int'(d) : int'(d);
    n_tests++;
    if (ad > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) tol %0d",
               tag, got, got, exp, exp, tol);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Present angle with a one-cycle start pulse. The call returns at the
  // negedge just after the accepting edge.
  task automatic start_op(input logic [31:0] a);
    @(negedge clk);
    bus.angle = a;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges until done is seen; -1 if the budget runs out.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      if (bus.done) begin
        cycles = n;
        break;
      end
    end
  endtask

  // Compare the current outputs with the oldest expected pair.
  task automatic score(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_x"}, bus.out_x, e[63:32], TOL);
      check({tag, "_y"}, bus.out_y, e[31:0], TOL);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a,
                         input logic [31:0] ex, input logic [31:0] ey);
    int cyc;
    exp_q.push_back({ex, ey});
    start_op(a);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, 32'd33, 0);
    score(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int dones;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.angle = '0;
    do_reset();

    @(negedge clk);
    check("rst_done",  {31'b0, bus.done}, 32'd0, 0);
    check("rst_x",     bus.out_x, 32'd0, 0);
    check("rst_y",     bus.out_y, 32'd0, 0);
    check("rst_state", {30'b0, dbg_state}, 32'd0, 0);

    run_vec("a0",    32'h0000_0000, 32'd2147483648, 32'd0);
    run_vec("pi4",   32'h8000_0000, 32'd1518500250, 32'd1518500250);
    run_vec("pi6",   32'd1431655770, 32'd1859775393, 32'd1073741824);
    run_vec("pi3",   32'd2863311540, 32'd1073741824, 32'd1859775393);
    run_vec("pi8",   32'h4000_0000, 32'd1984016189, 32'd821806413);
    run_vec("3pi8",  32'hC000_0000, 32'd821806413,  32'd1984016189);
    run_vec("top",   32'hFFFF_FFFE, 32'd2,          32'd2147483648);
`ifdef CORDIC_SATURATE_EN
    check("top_x_nowrap", {31'b0, bus.out_x[31]}, 32'd0, 0);
`endif

    // Outputs hold their value until the next DONE.
    repeat (5) @(negedge clk);
    check("hold_x", bus.out_x, 32'd2, TOL);

    // Start pulses and angle changes during RUN are ignored.
    exp_q.push_back({32'd1859775393, 32'd1073741824});
    start_op(32'd1431655770);
    repeat (10) @(negedge clk);
    bus.angle = 32'h0000_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    check("midrun_lat", cyc, 32'd22, 0);
    score("midrun");

    // With start held high, a result comes out every 34 cycles.
    exp_q.push_back({32'd1518500250, 32'd1518500250});
    exp_q.push_back({32'd1518500250, 32'd1518500250});
    @(negedge clk);
    bus.angle = 32'h8000_0000;
    bus.start = 1'b1;
    wait_done(cyc);
    check("thr_lat1", cyc, 32'd34, 0);
    score("thr1");
    wait_done(cyc);
    bus.start = 1'b0;
    check("thr_lat2", cyc, 32'd34, 0);
    score("thr2");

    // Reset during RUN aborts: no done, outputs back to 0.
    start_op(32'h4000_0000);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_x",     bus.out_x, 32'd0, 0);
    check("abort_y",     bus.out_y, 32'd0, 0);
    check("abort_state", {30'b0, dbg_state}, 32'd0, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_nodone", dones, 32'd0, 0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("rst_prio_state", {30'b0, dbg_state}, 32'd0, 0);

    // The engine still works after the abort.
    run_vec("post", 32'd2863311540, 32'd1073741824, 32'd1859775393);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
